// File: rtl/multi_phase_clkgen_pkg.sv
// Shared constants for the multi-phase clock generator: reset divisor,
// minimum legal divisor and the lock-tracking state encoding.
package clkgen_pkg;

  localparam int DEFAULT_DIV = 4;
  localparam int MIN_DIV     = 2;

  localparam logic [0:0] LOCKING = 1'b0;
  localparam logic [0:0] LOCKED  = 1'b1;

endpackage

// File: rtl/multi_phase_clkgen_if.sv
// Control/status bundle of the clock generator: divisor/offset load request
// going in, phase-offset square waves, edge pulses and status coming out.
interface multi_phase_clkgen_if #(
  parameter int NUM_PHASES = 2,
  parameter int DIV_WIDTH  = 8
);

  logic                            div_load;
  logic [DIV_WIDTH-1:0]            div_value;
  logic [NUM_PHASES*DIV_WIDTH-1:0] phase_off;
  logic [NUM_PHASES-1:0]           clk_out;
  logic [NUM_PHASES-1:0]           rise_en;
  logic [NUM_PHASES-1:0]           fall_en;
  logic [NUM_PHASES-1:0]           off_err;
  logic                            locked;

  modport master (
    output div_load, div_value, phase_off,
    input  clk_out, rise_en, fall_en, off_err, locked
  );

  modport slave (
    input  div_load, div_value, phase_off,
    output clk_out, rise_en, fall_en, off_err, locked
  );

endinterface

// File: rtl/multi_phase_clkgen_phase_channel.sv
// One output channel: a toggle flop that flips when the shared counter hits
// this channel's offset, plus registered rise/fall pulses and the offset error.
module phase_channel #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 restart_i,
  input  logic [DIV_WIDTH-1:0] cnt_i,
  input  logic [DIV_WIDTH-1:0] off_i,
  input  logic [DIV_WIDTH-1:0] new_off_i,
  input  logic [DIV_WIDTH-1:0] new_div_i,
  output logic                 clk_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 err_o
);

  logic clk_q, clk_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic err_q, err_d;
  logic toggle;

  // An out-of-range offset can never match the counter; gating on err_q
  // keeps the output parked low for the whole lifetime of that setting.
  assign toggle = !err_q && (cnt_i == off_i);

  always_comb begin
    clk_d  = clk_q ^ toggle;
    rise_d = toggle & ~clk_q;
    fall_d = toggle & clk_q;
    err_d  = err_q;
    if (restart_i) begin
      clk_d  = 1'b0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      err_d  = (new_off_i >= new_div_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      err_q  <= (new_off_i >= new_div_i);
    end else begin
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      err_q  <= err_d;
    end
  end

  assign clk_o  = clk_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign err_o  = err_q;

endmodule

// File: rtl/multi_phase_clkgen.sv
// Multi-phase clock generator: one shared 0..D-1 counter drives NUM_PHASES
// toggle channels; divisor/offset changes are deferred to a counter wrap.
module multi_phase_clkgen #(
  parameter int NUM_PHASES  = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = clkgen_pkg::DEFAULT_DIV
) (
  input  logic                  clkin,
  input  logic                  RST,
  multi_phase_clkgen_if.slave   bus
);

  import clkgen_pkg::*;

  localparam int OFFW = NUM_PHASES * DIV_WIDTH;
  localparam logic [DIV_WIDTH-1:0] MIN_D = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] RST_D = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [OFFW-1:0]      off_q, off_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic [OFFW-1:0]      pend_off_q, pend_off_d;
  logic [0:0]           state_q, state_d;
  logic                 wrapped_q, wrapped_d;

  logic                 wrap;
  logic                 apply;
  logic [DIV_WIDTH-1:0] load_div;
  logic [DIV_WIDTH-1:0] new_div;
  logic [OFFW-1:0]      new_off;

  logic [NUM_PHASES-1:0] clk_w, rise_w, fall_w, err_w;

  assign load_div = (bus.div_value < MIN_D) ? MIN_D : bus.div_value;
  assign wrap     = (cnt_q == div_q - 1'b1);
  assign apply    = wrap && (bus.div_load || pend_vld_q);

  // A request presented in the wrap cycle itself beats an older pending one;
  // under reset the channels reload from the port offsets and the reset divisor.
  always_comb begin
    new_div = pend_div_q;
    new_off = pend_off_q;
    if (RST) begin
      new_div = RST_D;
      new_off = bus.phase_off;
    end else if (bus.div_load) begin
      new_div = load_div;
      new_off = bus.phase_off;
    end
  end

  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    div_d      = div_q;
    off_d      = off_q;
    pend_vld_d = pend_vld_q;
    pend_div_d = pend_div_q;
    pend_off_d = pend_off_q;
    state_d    = state_q;
    wrapped_d  = wrapped_q;
    if (apply) begin
      div_d      = new_div;
      off_d      = new_off;
      pend_vld_d = 1'b0;
      state_d    = LOCKING;
      wrapped_d  = 1'b0;
    end else begin
      if (bus.div_load) begin
        pend_vld_d = 1'b1;
        pend_div_d = load_div;
        pend_off_d = bus.phase_off;
      end
      // Lock needs two complete wraps since the last apply or reset.
      if (wrap && state_q == LOCKING) begin
        if (wrapped_q) begin
          state_d   = LOCKED;
          wrapped_d = 1'b0;
        end else begin
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (RST) begin
      cnt_q      <= '0;
      div_q      <= RST_D;
      off_q      <= bus.phase_off;
      pend_vld_q <= 1'b0;
      pend_div_q <= '0;
      pend_off_q <= '0;
      state_q    <= LOCKING;
      wrapped_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      off_q      <= off_d;
      pend_vld_q <= pend_vld_d;
      pend_div_q <= pend_div_d;
      pend_off_q <= pend_off_d;
      state_q    <= state_d;
      wrapped_q  <= wrapped_d;
    end
  end

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_chan
    phase_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_chan (
      .clk_i     (clkin),
      .rst_i     (RST),
      .restart_i (apply),
      .cnt_i     (cnt_q),
      .off_i     (off_q[k*DIV_WIDTH +: DIV_WIDTH]),
      .new_off_i (new_off[k*DIV_WIDTH +: DIV_WIDTH]),
      .new_div_i (new_div),
      .clk_o     (clk_w[k]),
      .rise_o    (rise_w[k]),
      .fall_o    (fall_w[k]),
      .err_o     (err_w[k])
    );
  end

  assign bus.clk_out = clk_w;
  assign bus.rise_en = rise_w;
  assign bus.fall_en = fall_w;
  assign bus.off_err = err_w;
  assign bus.locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_multi_phase_clkgen.sv
// Self-checking bench for multi_phase_clkgen: directed table and corner
// sequences plus randomized traffic against an arithmetic reference model.
module tb_multi_phase_clkgen;

  localparam int NP   = 2;
  localparam int DW   = 8;
  localparam int DEF  = 4;
  localparam int OUTW = 4*NP + 1;

  typedef struct {
    bit               rst;
    logic [NP*DW-1:0] offs;
    logic [NP-1:0]    expClk;
    bit               expLocked;
  } vec_t;

  logic clkin = 1'b0;
  logic RST;

  int vecCount  = 0;
  int missCount = 0;

  int   mD;
  int   mN;
  int   mOff [NP];
  bit   mPend;
  int   pD;
  int   pOff [NP];
  logic [NP*DW-1:0] offsIn;

  multi_phase_clkgen_if #(.NUM_PHASES(NP), .DIV_WIDTH(DW)) bus ();

  multi_phase_clkgen #(
    .NUM_PHASES  (NP),
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clkin (clkin),
    .RST   (RST),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  // Number of toggles a channel has made n cycles after a restart: one per
  // period D, the first when the counter (n-1 mod D) first equals the offset.
  function automatic int toggles(int off, int d, int n);
    if (off >= d || n <= off) return 0;
    return (n - 1 - off) / d + 1;
  endfunction

  task automatic modelStep(bit rst, bit load, int div, logic [NP*DW-1:0] offv);
    int ld;
    ld = (div < 2) ? 2 : div;
    if (rst) begin
      mD = DEF;
      for (int k = 0; k < NP; k++) mOff[k] = int'(offv[k*DW +: DW]);
      mN = 0;
      mPend = 0;
    end else if ((mN % mD == mD - 1) && (load || mPend)) begin
      if (load) begin
        mD = ld;
        for (int k = 0; k < NP; k++) mOff[k] = int'(offv[k*DW +: DW]);
      end else begin
        mD = pD;
        for (int k = 0; k < NP; k++) mOff[k] = pOff[k];
      end
      mN = 0;
      mPend = 0;
    end else begin
      if (load) begin
        mPend = 1;
        pD = ld;
        for (int k = 0; k < NP; k++) pOff[k] = int'(offv[k*DW +: DW]);
      end
      mN++;
    end
  endtask

  function automatic logic [OUTW-1:0] modelOut();
    logic [NP-1:0] c, r, f, e;
    int  t;
    bit  hit;
    for (int k = 0; k < NP; k++) begin
      t    = toggles(mOff[k], mD, mN);
      hit  = (mN > 0) && (mOff[k] < mD) && ((mN - 1) % mD == mOff[k]);
      c[k] = t[0];
      r[k] = hit && t[0];
      f[k] = hit && !t[0];
      e[k] = (mOff[k] >= mD);
    end
    return {c, r, f, e, (mN >= 2*mD)};
  endfunction

  task automatic checkOutput();
    logic [OUTW-1:0] act, exp;
    act = {bus.clk_out, bus.rise_en, bus.fall_en, bus.off_err, bus.locked};
    exp = modelOut();
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL model t=%0t: got clk/rise/fall/err/lock=%b required %b", $time, act, exp);
    end
  endtask

  task automatic handCheck(string name, logic [31:0] act, logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s t=%0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic timeoutFail(string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: timed out, got no event required event", name);
  endtask

  task automatic applyStimulus(bit rst, bit load, int div, logic [NP*DW-1:0] offv);
    RST           = rst;
    bus.div_load  = load;
    bus.div_value = DW'(div);
    bus.phase_off = offv;
    offsIn        = offv;
    @(posedge clkin);
    modelStep(rst, load, div, offv);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, offsIn);
  endtask

  task automatic waitApply(string name);
    bit done;
    done = (mN == 0);
    for (int i = 0; i < 60 && !done; i++) begin
      idle();
      done = (mN == 0);
    end
    if (!done) timeoutFail(name);
  endtask

  task automatic stepUntilCnt(int target, string name);
    bit done;
    done = (mN % mD == target);
    for (int i = 0; i < 60 && !done; i++) begin
      idle();
      done = (mN % mD == target);
    end
    if (!done) timeoutFail(name);
  endtask

  task automatic measurePeriod(int ch, int expP, string name);
    int first, second;
    first  = -1;
    second = -1;
    for (int i = 0; i < 200 && second < 0; i++) begin
      idle();
      if (bus.rise_en[ch]) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    if (second < 0) timeoutFail(name);
    else handCheck(name, second - first, expP);
  endtask

  vec_t tbl [15];
  bit   sawHigh;
  bit   rr, rl;
  int   rd;
  logic [NP*DW-1:0] ro;

  initial begin
    RST           = 1'b1;
    bus.div_load  = 1'b0;
    bus.div_value = '0;
    bus.phase_off = 16'h0301;
    offsIn        = 16'h0301;
    mD = DEF; mN = 0; mPend = 0; pD = DEF;
    for (int k = 0; k < NP; k++) begin mOff[k] = 0; pOff[k] = 0; end

    // Channel 0 offset 1, channel 1 offset 3, D=4: ch1 lags ch0 by 2 cycles,
    // locked appears after the second wrap (8 cycles after reset release).
    tbl = '{
      '{1'b1, 16'h0301, 2'b00, 1'b0},
      '{1'b1, 16'h0301, 2'b00, 1'b0},
      '{1'b1, 16'h0301, 2'b00, 1'b0},
      '{1'b0, 16'h0301, 2'b00, 1'b0},
      '{1'b0, 16'h0301, 2'b01, 1'b0},
      '{1'b0, 16'h0301, 2'b01, 1'b0},
      '{1'b0, 16'h0301, 2'b11, 1'b0},
      '{1'b0, 16'h0301, 2'b11, 1'b0},
      '{1'b0, 16'h0301, 2'b10, 1'b0},
      '{1'b0, 16'h0301, 2'b10, 1'b0},
      '{1'b0, 16'h0301, 2'b00, 1'b1},
      '{1'b0, 16'h0301, 2'b00, 1'b1},
      '{1'b0, 16'h0301, 2'b01, 1'b1},
      '{1'b0, 16'h0301, 2'b01, 1'b1},
      '{1'b0, 16'h0301, 2'b11, 1'b1}
    };

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].rst, 1'b0, 0, tbl[i].offs);
      handCheck($sformatf("table clk_out row %0d", i), bus.clk_out, tbl[i].expClk);
      handCheck($sformatf("table locked row %0d", i), bus.locked, tbl[i].expLocked);
    end

    // Mid-period load of D=6: nothing changes until the wrap at cnt==3.
    idle();
    applyStimulus(1'b0, 1'b1, 6, 16'h0301);
    handCheck("locked held while pending", bus.locked, 1);
    waitApply("apply D=6");
    handCheck("clk_out cleared at apply", bus.clk_out, 0);
    handCheck("locked dropped at apply", bus.locked, 0);
    repeat (11) idle();
    handCheck("still locking after 11", bus.locked, 0);
    idle();
    handCheck("locked after 12", bus.locked, 1);
    measurePeriod(0, 12, "period D=6");

    // Divisor 0 clamps to 2.
    applyStimulus(1'b0, 1'b1, 0, 16'h0100);
    waitApply("apply D=0");
    handCheck("off_err clamp", bus.off_err, 0);
    measurePeriod(0, 4, "period clamped D=2");

    // Offset 5 with D=4 parks channel 1 low and flags it.
    applyStimulus(1'b0, 1'b1, 4, 16'h0501);
    waitApply("apply bad offset");
    handCheck("off_err bad offset", bus.off_err, 2'b10);
    sawHigh = 0;
    repeat (12) begin
      idle();
      if (bus.clk_out[1]) sawHigh = 1;
    end
    handCheck("clk_out[1] stuck low", sawHigh, 0);
    applyStimulus(1'b0, 1'b1, 4, 16'h0101);
    waitApply("apply good offset");
    handCheck("off_err cleared", bus.off_err, 0);

    // Two loads before one wrap: only the later one takes effect.
    stepUntilCnt(0, "reach cnt 0");
    applyStimulus(1'b0, 1'b1, 5, 16'h0201);
    applyStimulus(1'b0, 1'b1, 7, 16'h0201);
    waitApply("apply D=7");
    measurePeriod(0, 14, "period D=7 only");

    // Reset coinciding with a load at wrap discards everything pending.
    stepUntilCnt(0, "reach cnt 0 again");
    applyStimulus(1'b0, 1'b1, 9, 16'h0301);
    stepUntilCnt(mD - 1, "reach wrap cycle");
    applyStimulus(1'b1, 1'b1, 6, 16'h0301);
    handCheck("reset beats load clk_out", bus.clk_out, 0);
    handCheck("reset beats load locked", bus.locked, 0);
    measurePeriod(0, 2*DEF, "period default after reset");

    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      rl = ($urandom_range(0, 7) == 0);
      rd = int'($urandom_range(0, 9));
      for (int k = 0; k < NP; k++) ro[k*DW +: DW] = DW'($urandom_range(0, 10));
      applyStimulus(rr, rl, rd, ro);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
